// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front-end.
// Holds the loader FSM state encoding and the pixel width.
package conv_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READY,
    LOAD_ROW,
    DONE
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector with registered history.
// rise is high while d is 1 and the previous sample was 0.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/row_buffer_loader.sv
// Row buffer loader: fills FILTER_SIZE image rows, then slides one row per request.
// Optional sticky err output is built in when ROW_LOADER_ERR_EN is defined.
module row_buffer_loader
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [PIX_W-1:0]                        pix_in,
  input  logic                                    pix_valid,
  output logic                                    pix_ready,
  input  logic                                    new_buffer,
  output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] row_buffer_out,
  output logic                                    shift_en,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]         row_idx,
  output logic                                    frame_done
`ifdef ROW_LOADER_ERR_EN
  ,
  output logic                                    err
`endif
);

  localparam int CW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int RIW = $clog2(IMAGE_HEIGHT);

  localparam logic [CW-1:0]  LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]  LAST_FR  = RW'(FILTER_SIZE - 1);
  localparam logic [RIW-1:0] LAST_ROW = RIW'(IMAGE_HEIGHT - FILTER_SIZE);

  state_t state_q, state_d;

  logic [PIX_W-1:0] mem_q [FILTER_SIZE][IMAGE_WIDTH];
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    fill_row_q;
  logic [RIW-1:0]   row_idx_q;
  logic             shift_en_q;

  logic req;
  logic xfer;
  logic clr;
  logic shift_up;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (new_buffer),
    .rise (req)
  );

  assign pix_ready  = (state_q == FILL) || (state_q == LOAD_ROW);
  assign xfer       = pix_valid & pix_ready;
  assign shift_en   = shift_en_q;
  assign row_idx    = row_idx_q;
  assign frame_done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    shift_up = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          clr     = 1'b1;
        end
      end
      FILL: begin
        if (xfer && fill_row_q == LAST_FR && col_q == LAST_COL)
          state_d = READY;
      end
      READY: begin
        if (req) begin
          if (row_idx_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            state_d  = LOAD_ROW;
            shift_up = 1'b1;
          end
        end
      end
      LOAD_ROW: begin
        if (xfer && col_q == LAST_COL)
          state_d = READY;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes only happen in FILL/LOAD_ROW, shifts only in READY: never both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < FILTER_SIZE; r++)
        for (int c = 0; c < IMAGE_WIDTH; c++)
          mem_q[r][c] <= '0;
      col_q      <= '0;
      fill_row_q <= '0;
      row_idx_q  <= '0;
      shift_en_q <= 1'b0;
    end else begin
      shift_en_q <= (state_d == READY) && (state_q != READY);
      if (clr) begin
        col_q      <= '0;
        fill_row_q <= '0;
        row_idx_q  <= '0;
      end
      if (xfer) begin
        if (state_q == FILL) mem_q[fill_row_q][col_q] <= pix_in;
        else                 mem_q[LAST_FR][col_q]    <= pix_in;
        if (col_q == LAST_COL) begin
          col_q <= '0;
          if (state_q == FILL) fill_row_q <= fill_row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (shift_up) begin
        for (int r = 0; r < FILTER_SIZE - 1; r++)
          mem_q[r] <= mem_q[r+1];
        row_idx_q <= row_idx_q + 1'b1;
        col_q     <= '0;
      end
    end
  end

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < IMAGE_WIDTH; c++) begin : g_col
      assign row_buffer_out[(r*IMAGE_WIDTH+c)*PIX_W +: PIX_W] = mem_q[r][c];
    end
  end

`ifdef ROW_LOADER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((req && pix_ready) || (start && state_q != IDLE)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_row_buffer_loader.sv
// Directed self-checking bench for row_buffer_loader (default 128x128x3).
// Covers fill, advance, reset mid-row, throttled fill and a full frame.
module tb_row_buffer_loader;

  localparam int W  = 128;
  localparam int H  = 128;
  localparam int FS = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [7:0]            pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  new_buffer;
  logic [FS*W*8-1:0]     row_buffer_out;
  logic                  shift_en;
  logic [$clog2(H)-1:0]  row_idx;
  logic                  frame_done;
`ifdef ROW_LOADER_ERR_EN
  logic                  err;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int shifts = 0;
  int dones  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  row_buffer_loader #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .FILTER_SIZE  (FS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .new_buffer     (new_buffer),
    .row_buffer_out (row_buffer_out),
    .shift_en       (shift_en),
    .row_idx        (row_idx),
    .frame_done     (frame_done)
`ifdef ROW_LOADER_ERR_EN
    ,
    .err            (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (pix_valid && pix_ready) xfers++;
    @(posedge clk);
    #1;
    if (shift_en)   shifts++;
    if (frame_done) dones++;
  endtask

  // Reports the first pixel in row r that differs from exp.
  task automatic chk_row(input string tag, input int r, input logic [7:0] exp);
    logic [7:0] got;
    logic [7:0] p;
    got = exp;
    for (int c = 0; c < W; c++) begin
      p = row_buffer_out[(r*W+c)*8 +: 8];
      if (p !== exp && got === exp) got = p;
    end
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    pix_in     = '0;
    pix_valid  = 1'b0;
    new_buffer = 1'b0;
    #3;
    chk("rst_shift_en", 32'(shift_en), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    chk("rst_buf_zero", 32'(row_buffer_out == '0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // idle ignores pixels
    pix_valid = 1'b1;
    tick();
    tick();
    chk("idle_ready", 32'(pix_ready), 32'd0);
    chk("idle_xfers", 32'(xfers), 32'd0);
    pix_valid = 1'b0;

    // fill 3 rows, value = row index
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_ready", 32'(pix_ready), 32'd1);
    xfers  = 0;
    shifts = 0;
    for (int k = 0; k < FS*W; k++) begin
      pix_in    = 8'(k / W);
      pix_valid = 1'b1;
      tick();
      if (k == FS*W-2) chk("fill_no_early_shift", 32'(shift_en), 32'd0);
    end
    chk("fill_shift_en", 32'(shift_en), 32'd1);
    chk("fill_ready_off", 32'(pix_ready), 32'd0);
    chk("fill_xfers", 32'(xfers), 32'd384);
    pix_in = 8'hAA;
    tick();
    tick();
    tick();
    pix_valid = 1'b0;
    chk("fill_shift_pulse", 32'(shifts), 32'd1);
    chk_row("fill_row0", 0, 8'd0);
    chk_row("fill_row1", 1, 8'd1);
    chk_row("fill_row2", 2, 8'd2);
    chk("fill_row_idx", 32'(row_idx), 32'd0);

    // held request = one advance
    shifts     = 0;
    new_buffer = 1'b1;
    tick();
    chk("adv_row_idx", 32'(row_idx), 32'd1);
    chk("adv_ready", 32'(pix_ready), 32'd1);
    chk_row("adv_shift_row0", 0, 8'd1);
    chk_row("adv_shift_row1", 1, 8'd2);
    tick();
    new_buffer = 1'b0;
    chk("adv_held_row_idx", 32'(row_idx), 32'd1);
    for (int c = 0; c < W; c++) begin
      pix_in    = 8'd3;
      pix_valid = 1'b1;
      tick();
    end
    chk("adv_shift_en", 32'(shift_en), 32'd1);
    pix_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("adv_shifts", 32'(shifts), 32'd1);
    chk_row("adv_row0", 0, 8'd1);
    chk_row("adv_row1", 1, 8'd2);
    chk_row("adv_row2", 2, 8'd3);
    chk("adv_row_idx_end", 32'(row_idx), 32'd1);

    // async reset in the middle of LOAD_ROW
    new_buffer = 1'b1;
    tick();
    new_buffer = 1'b0;
    chk("mid_row_idx", 32'(row_idx), 32'd2);
    pix_in    = 8'd9;
    pix_valid = 1'b1;
    for (int c = 0; c < 50; c++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_buf_zero", 32'(row_buffer_out == '0), 32'd1);
    chk("arst_ready", 32'(pix_ready), 32'd0);
    chk("arst_row_idx", 32'(row_idx), 32'd0);
    chk("arst_shift_en", 32'(shift_en), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
`ifdef ROW_LOADER_ERR_EN
    chk("arst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) tick();
    chk("post_rst_ready", 32'(pix_ready), 32'd0);
    chk("post_rst_buf", 32'(row_buffer_out == '0), 32'd1);
    pix_valid = 1'b0;

    // throttled fill, stray request during FILL
    start = 1'b1;
    tick();
    start  = 1'b0;
    xfers  = 0;
    shifts = 0;
    cyc    = 0;
    for (int i = 0; i < 1000 && xfers < FS*W; i++) begin
      pix_valid  = (i % 2 == 0);
      pix_in     = pix_valid ? 8'(xfers / W) : 8'hFF;
      new_buffer = (i == 100);
      tick();
      cyc++;
    end
    pix_valid  = 1'b0;
    new_buffer = 1'b0;
    chk("thr_xfers", 32'(xfers), 32'd384);
    chk("thr_cycles", 32'(cyc), 32'd767);
    chk("thr_shift_en", 32'(shift_en), 32'd1);
    chk("thr_shifts", 32'(shifts), 32'd1);
`ifdef ROW_LOADER_ERR_EN
    chk("thr_err", 32'(err), 32'd1);
`endif
    tick();
    chk_row("thr_row0", 0, 8'd0);
    chk_row("thr_row1", 1, 8'd1);
    chk_row("thr_row2", 2, 8'd2);
    chk("thr_row_idx", 32'(row_idx), 32'd0);

    // rest of the frame: 125 advances then the terminating request
    for (int req = 1; req <= H - FS; req++) begin
      new_buffer = 1'b1;
      tick();
      new_buffer = 1'b0;
      for (int c = 0; c < W; c++) begin
        pix_in    = 8'(req + FS - 1);
        pix_valid = 1'b1;
        start     = (req == 60 && c == 10);
        tick();
      end
      start     = 1'b0;
      pix_valid = 1'b0;
    end
    chk("frm_row_idx", 32'(row_idx), 32'd125);
    chk("frm_shifts", 32'(shifts), 32'd126);
    chk("frm_xfers", 32'(xfers), 32'd16384);
    chk("frm_no_done", 32'(dones), 32'd0);
    chk_row("frm_row0", 0, 8'd125);
    chk_row("frm_row1", 1, 8'd126);
    chk_row("frm_row2", 2, 8'd127);
    new_buffer = 1'b1;
    tick();
    new_buffer = 1'b0;
    chk("frm_done", 32'(frame_done), 32'd1);
    chk("frm_done_row_idx", 32'(row_idx), 32'd125);
    tick();
    chk("frm_done_pulse", 32'(frame_done), 32'd0);
    chk("frm_done_count", 32'(dones), 32'd1);
    chk("frm_idle_ready", 32'(pix_ready), 32'd0);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("frm_idle_xfers", 32'(xfers), 32'd16384);
`ifdef ROW_LOADER_ERR_EN
    chk("frm_err_sticky", 32'(err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
